// File: rtl/digit_scan_ctrl.sv
// rtl/digit_scan_ctrl.sv - channel sequencer driving a 2-to-4 decoder select/enable
module digit_scan_ctrl #(
  parameter int DWELL_W = 8,
  parameter int BLANK_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [BLANK_W-1:0] blank,
  input  logic [3:0]         mask,
  output logic [1:0]         sel,
  output logic               sel_en,
  output logic               frame_done,
  output logic               busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BLANK  = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;

  logic [1:0]         state;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [BLANK_W-1:0] blank_cnt;

  logic [DWELL_W-1:0] dwell_eff;
  logic [1:0]         enter_idx;
  logic               enter_ch;
  logic               blank_done;
  logic               active_more;

  // Lowest set mask bit; only meaningful when the mask is non-zero.
  function automatic logic [1:0] lowest_bit(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Next set mask bit strictly after cur, wrapping 3 -> 0; cur itself is the last candidate.
  function automatic logic [1:0] next_bit(input logic [1:0] cur, input logic [3:0] m);
    logic [1:0] r;
    logic [1:0] c;
    logic       found;
    r     = cur;
    found = 1'b0;
    for (int k = 1; k < 5; k++) begin
      c = cur + 2'(k);
      if (!found && m[c]) begin
        r     = c;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // True when leaving channel cur ends the frame: no enabled channel above cur.
  function automatic logic frame_end(input logic [1:0] cur, input logic [3:0] m);
    return (m != 4'd0) && (((m >> cur) >> 1) == 4'd0);
  endfunction

  // Channel-entry decode: start from idle or advance after the last active cycle.
  always_comb begin
    dwell_eff   = (dwell == '0) ? DWELL_W'(1) : dwell;
    enter_idx   = (state == S_IDLE) ? lowest_bit(mask) : next_bit(sel, mask);
    enter_ch    = (mask != 4'd0) &&
                  ((state == S_IDLE) || ((state == S_ACTIVE) && (dwell_cnt <= DWELL_W'(1))));
    blank_done  = (state == S_BLANK) && (blank_cnt <= BLANK_W'(1));
    active_more = (state == S_ACTIVE) && (dwell_cnt > DWELL_W'(1));
  end

  // Sequencer state, counters and all registered outputs; frame_done is predicted one edge ahead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      sel        <= 2'b00;
      sel_en     <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      dwell_cnt  <= '0;
      blank_cnt  <= '0;
    end else if (!run) begin
      state      <= S_IDLE;
      sel_en     <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else if (enter_ch) begin
      sel  <= enter_idx;
      busy <= 1'b1;
      if (blank != '0) begin
        state      <= S_BLANK;
        blank_cnt  <= blank;
        sel_en     <= 1'b0;
        frame_done <= 1'b0;
      end else begin
        state      <= S_ACTIVE;
        dwell_cnt  <= dwell_eff;
        sel_en     <= 1'b1;
        frame_done <= (dwell_eff == DWELL_W'(1)) && frame_end(enter_idx, mask);
      end
    end else if (blank_done) begin
      state      <= S_ACTIVE;
      dwell_cnt  <= dwell_eff;
      sel_en     <= 1'b1;
      frame_done <= (dwell_eff == DWELL_W'(1)) && frame_end(sel, mask);
    end else if (active_more) begin
      dwell_cnt  <= dwell_cnt - DWELL_W'(1);
      frame_done <= (dwell_cnt == DWELL_W'(2)) && frame_end(sel, mask);
    end else if (state == S_ACTIVE) begin
      state      <= S_IDLE;
      sel_en     <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else if (state == S_BLANK) begin
      blank_cnt  <= blank_cnt - BLANK_W'(1);
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb/tb_digit_scan_ctrl.sv - self-checking bench for digit_scan_ctrl
module tb_digit_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [7:0] dwell;
  logic [3:0] blank;
  logic [3:0] mask;
  logic [1:0] sel;
  logic       sel_en;
  logic       frame_done;
  logic       busy;

  digit_scan_ctrl #(.DWELL_W(8), .BLANK_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .dwell(dwell), .blank(blank), .mask(mask),
    .sel(sel), .sel_en(sel_en), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each started channel expands into a schedule of per-cycle outputs.
  typedef struct packed {
    logic [1:0] s;
    logic       en;
    logic       last;
  } ent_t;

  ent_t       q[$];
  bit         m_idle = 1'b1;
  logic [1:0] m_sel  = 2'd0;
  logic       m_en   = 1'b0;
  logic       m_fd   = 1'b0;
  logic       m_busy = 1'b0;

  function automatic bit nothing_above(input logic [1:0] c, input logic [3:0] m);
    if (m == 4'd0) return 1'b0;
    for (int i = int'(c) + 1; i < 4; i++) if (m[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [1:0] lowest(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return 2'(i);
    return 2'd0;
  endfunction

  function automatic logic [1:0] next_ch(input logic [1:0] c, input logic [3:0] m);
    for (int k = 1; k <= 4; k++) if (m[(int'(c) + k) % 4]) return 2'((int'(c) + k) % 4);
    return c;
  endfunction

  task automatic fill(input logic [1:0] c);
    int d;
    ent_t e;
    for (int b = 0; b < int'(blank); b++) begin
      e = '{s: c, en: 1'b0, last: 1'b0};
      q.push_back(e);
    end
    d = (dwell == 8'd0) ? 1 : int'(dwell);
    for (int k = 0; k < d; k++) begin
      e = '{s: c, en: 1'b1, last: (k == d - 1)};
      q.push_back(e);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    ent_t e;
    if (!rst_n) begin
      q.delete();
      m_idle = 1'b1; m_sel = 2'd0; m_en = 1'b0; m_fd = 1'b0; m_busy = 1'b0;
    end else if (!run) begin
      q.delete();
      m_idle = 1'b1; m_en = 1'b0; m_fd = 1'b0; m_busy = 1'b0;
    end else begin
      if (q.size() == 0 && mask != 4'd0) fill(m_idle ? lowest(mask) : next_ch(m_sel, mask));
      if (q.size() == 0) begin
        m_idle = 1'b1; m_en = 1'b0; m_fd = 1'b0; m_busy = 1'b0;
      end else begin
        e = q.pop_front();
        m_idle = 1'b0;
        m_sel  = e.s;
        m_en   = e.en;
        m_busy = 1'b1;
        m_fd   = e.last && nothing_above(e.s, mask);
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("sel", sel, m_sel);
      check("sel_en", sel_en, m_en);
      check("frame_done", frame_done, m_fd);
      check("busy", busy, m_busy);
    end
  end

  int b_sel[12]  = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1};
  int k_sel[12]  = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
  int k_en[12]   = '{0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
  int m5_sel[5]  = '{0, 2, 0, 2, 0};
  int single_fd[6] = '{0, 0, 1, 0, 0, 1};

  task automatic stop_run();
    @(negedge clk); run = 1'b0;
    @(negedge clk);
    check("stop_en", sel_en, 0);
    check("stop_busy", busy, 0);
    @(negedge clk);
  endtask

  initial begin
    int cnt0;
    rst_n = 1'b0; run = 1'b0; dwell = 8'd2; blank = 4'd0; mask = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_sel", sel, 0);
    check("rst_en", sel_en, 0);
    check("rst_busy", busy, 0);
    check("rst_fd", frame_done, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // basic scan, no blanking
    run = 1'b1; dwell = 8'd2; blank = 4'd0; mask = 4'hF;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("basic_sel", sel, b_sel[i]);
      check("basic_model_sel", m_sel, b_sel[i]);
      check("basic_en", sel_en, 1);
      check("basic_fd", frame_done, (i == 7));
    end
    stop_run();

    // blanking gap before each channel
    run = 1'b1; dwell = 8'd2; blank = 4'd1; mask = 4'hF;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("blank_sel", sel, k_sel[i]);
      check("blank_en", sel_en, k_en[i]);
      check("blank_model_en", m_en, k_en[i]);
      check("blank_fd", frame_done, (i == 11));
    end
    stop_run();

    // sparse mask, then mask removed mid-scan
    run = 1'b1; dwell = 8'd1; blank = 4'd0; mask = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mask_sel", sel, m5_sel[i]);
      check("mask_fd", frame_done, (m5_sel[i] == 2));
    end
    mask = 4'd0;
    @(negedge clk);
    check("mask0_en", sel_en, 0);
    check("mask0_busy", busy, 0);
    check("mask0_sel", sel, 0);
    repeat (2) @(negedge clk);
    run = 1'b0;
    @(negedge clk);

    // stop during channel 1, restart with channel 0 disabled
    run = 1'b1; dwell = 8'd3; blank = 4'd0; mask = 4'hF;
    repeat (4) @(negedge clk);
    check("stop_pre_sel", sel, 1);
    run = 1'b0;
    @(negedge clk);
    check("stop_sel_hold", sel, 1);
    check("stop_en0", sel_en, 0);
    check("stop_busy0", busy, 0);
    mask = 4'b1110; run = 1'b1;
    @(negedge clk);
    check("restart_sel", sel, 1);
    check("restart_en", sel_en, 1);
    repeat (8) @(negedge clk);
    stop_run();

    // dwell of zero behaves as one cycle per channel
    run = 1'b1; dwell = 8'd0; blank = 4'd0; mask = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("dwell0_sel", sel, i % 4);
      check("dwell0_fd", frame_done, (i == 3));
    end
    stop_run();

    // single enabled channel
    run = 1'b1; dwell = 8'd3; blank = 4'd0; mask = 4'b1000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("single_sel", sel, 3);
      check("single_fd", frame_done, single_fd[i]);
    end
    stop_run();

    // maximum dwell
    run = 1'b1; dwell = 8'hFF; blank = 4'd2; mask = 4'b0011;
    cnt0 = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sel_en && sel == 2'd0) cnt0++;
    end
    check("dwell_max_cycles", cnt0, 255);
    stop_run();

    // asynchronous reset in the middle of an active channel
    run = 1'b1; dwell = 8'd4; blank = 4'd0; mask = 4'b0100;
    repeat (2) @(negedge clk);
    check("pre_rst_sel", sel, 2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sel", sel, 0);
    check("async_rst_en", sel_en, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_fd", frame_done, 0);
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=%0d required=%0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule
